// File: rtl/divider_cfg_if.sv
// Configuration handshake and even-divider control bundle for divider_cfg.
// WIDTH must match the WIDTH of the divider_cfg instance it is bound to.
interface divider_cfg_if #(
  parameter int WIDTH = 32
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_n;
  logic             div_out;
  logic [WIDTH-1:0] div_n;
  logic             div_enable;
  logic             busy;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_n, div_out,
    input  cfg_ready, div_n, div_enable, busy, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_n, div_out,
    output cfg_ready, div_n, div_enable, busy, cfg_err
  );
endinterface

// File: rtl/divider_cfg.sv
// Safe reconfiguration of an external even clock divider: drain on a low
// divided-clock phase, load the new factor, let it settle, then re-enable.
//
// state  | meaning
// IDLE   | divider stopped, accepting configuration
// DRAIN  | waiting for div_out low before dropping div_enable
// LOAD   | copying pending factor to div_n
// SETTLE | div_n held stable for SETTLE cycles (down-counter to 0)
// RUN    | divider enabled, accepting configuration
module divider_cfg #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 4
) (
  input  logic           clk,
  input  logic           reset,
  divider_cfg_if.slave   bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRAIN  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;

  localparam logic [WIDTH-1:0] DIV_N_RST  = WIDTH'(2);
  localparam logic [7:0]       SETTLE_TOP = 8'(SETTLE - 1);

  logic [2:0]       state;
  logic [WIDTH-1:0] div_n_q;
  logic [WIDTH-1:0] pending;
  logic             pend_stop;
  logic             div_en_q;
  logic             err_q;
  logic [7:0]       settle_cnt;

  logic xfer;
  logic is_stop;
  logic is_odd;

  assign bus.cfg_ready  = (state == ST_IDLE) || (state == ST_RUN);
  assign bus.busy       = (state == ST_DRAIN) || (state == ST_LOAD) ||
                          (state == ST_SETTLE);
  assign bus.div_n      = div_n_q;
  assign bus.div_enable = div_en_q;
  assign bus.cfg_err    = err_q;

  assign xfer    = bus.cfg_valid && bus.cfg_ready;
  assign is_stop = (bus.cfg_n == '0);
  assign is_odd  = bus.cfg_n[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      div_n_q    <= DIV_N_RST;
      pending    <= DIV_N_RST;
      pend_stop  <= 1'b0;
      div_en_q   <= 1'b0;
      err_q      <= 1'b0;
      settle_cnt <= 8'd0;
    end else begin
      case (state)
        ST_IDLE, ST_RUN: begin
          if (xfer) begin
            if (is_odd) begin
              // Illegal factor: flag it and leave the running divider alone.
              err_q <= 1'b1;
            end else begin
              err_q     <= 1'b0;
              pend_stop <= is_stop;
              if (!is_stop) pending <= bus.cfg_n;
              if (div_en_q)     state <= ST_DRAIN;
              else if (!is_stop) state <= ST_LOAD;
            end
          end
        end
        ST_DRAIN: begin
          if (!bus.div_out) begin
            div_en_q <= 1'b0;
            state    <= pend_stop ? ST_IDLE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          div_n_q    <= pending;
          settle_cnt <= SETTLE_TOP;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == 8'd0) begin
            div_en_q <= 1'b1;
            state    <= ST_RUN;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_cfg.sv
// Self-checking bench for divider_cfg: directed scenarios plus randomized
// transfers checked against a cycle-level behavioural model.
module tb_divider_cfg;
  localparam int WIDTH  = 32;
  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic reset;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [WIDTH-1:0] m_div_n;
  logic             m_en;
  logic             m_err;

  divider_cfg_if #(.WIDTH(WIDTH)) bus ();

  divider_cfg #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_div_n"}, bus.div_n, m_div_n);
    chk({tag, "_en"},    {31'd0, bus.div_enable}, {31'd0, m_en});
    chk({tag, "_err"},   {31'd0, bus.cfg_err}, {31'd0, m_err});
    chk({tag, "_ready"}, {31'd0, bus.cfg_ready}, 32'd1);
    chk({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
  endtask

  // While busy, optionally keep cfg_valid high with junk that must be ignored.
  task automatic drive_noise(input bit noise);
    bus.cfg_valid = noise;
    bus.cfg_n     = $urandom;
  endtask

  // Called at a negedge with the block quiescent; ends at a negedge quiescent.
  task automatic transfer(input logic [31:0] v, input int drain, input bit noise);
    chk_quiet("pre");
    bus.cfg_valid = 1'b1;
    bus.cfg_n     = v;
    bus.div_out   = (drain > 0);
    @(negedge clk);
    if (v[0]) begin
      bus.cfg_valid = 1'b0;
      m_err = 1'b1;
      chk_quiet("odd");
    end else if (v == 0 && !m_en) begin
      bus.cfg_valid = 1'b0;
      m_err = 1'b0;
      chk_quiet("stop_idle");
    end else begin
      m_err = 1'b0;
      if (m_en) begin
        chk("drain_en",    {31'd0, bus.div_enable}, 32'd1);
        chk("drain_busy",  {31'd0, bus.busy}, 32'd1);
        chk("drain_ready", {31'd0, bus.cfg_ready}, 32'd0);
        for (int j = 0; j < drain; j++) begin
          drive_noise(noise);
          @(negedge clk);
          chk("drain_hold_en", {31'd0, bus.div_enable}, 32'd1);
          chk("drain_hold_n",  bus.div_n, m_div_n);
        end
        bus.div_out = 1'b0;
        drive_noise(noise);
        @(negedge clk);
        chk("drain_fall_en", {31'd0, bus.div_enable}, 32'd0);
        chk("drain_fall_n",  bus.div_n, m_div_n);
        m_en = 1'b0;
        if (v == 0) begin
          bus.cfg_valid = 1'b0;
          chk_quiet("stop_done");
          return;
        end
      end
      chk("load_busy", {31'd0, bus.busy}, 32'd1);
      chk("load_n",    bus.div_n, m_div_n);
      chk("load_en",   {31'd0, bus.div_enable}, 32'd0);
      for (int i = 1; i <= SETTLE + 1; i++) begin
        drive_noise(noise);
        @(negedge clk);
        chk("settle_n",    bus.div_n, v);
        chk("settle_en",   {31'd0, bus.div_enable}, {31'd0, (i == SETTLE + 1)});
        chk("settle_busy", {31'd0, bus.busy}, {31'd0, (i <= SETTLE)});
      end
      bus.cfg_valid = 1'b0;
      m_div_n = v;
      m_en    = 1'b1;
      chk_quiet("run");
    end
  endtask

  task automatic gap(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk_quiet("gap");
    end
  endtask

  initial begin
    logic [31:0] v;
    reset         = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_n     = '0;
    bus.div_out   = 1'b0;
    m_div_n = 32'd2;
    m_en    = 1'b0;
    m_err   = 1'b0;
    #3;
    chk_quiet("reset");
    @(negedge clk);
    reset = 1'b0;
    gap(2);

    transfer(32'd8, 0, 1'b0);
    gap(2);
    transfer(32'd4, 3, 1'b0);
    gap(1);

    transfer(32'd7, 0, 1'b0);
    transfer(32'd1, 0, 1'b0);
    gap(2);
    transfer(32'd6, 1, 1'b0);

    transfer(32'd0, 2, 1'b0);
    gap(1);
    transfer(32'd0, 0, 1'b0);
    gap(1);

    transfer(32'd10, 0, 1'b1);
    transfer(32'd12, 1, 1'b1);
    transfer(32'd14, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0:       v = 32'd0;
        1:       v = 32'($urandom_range(0, 1000)) * 2 + 1;
        default: v = 32'($urandom_range(1, 1000)) * 2;
      endcase
      transfer(v, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      gap(int'($urandom_range(0, 3)));
    end

    // Reset while settling with the counter at 2.
    transfer(32'd0, 0, 1'b0);
    bus.cfg_valid = 1'b1;
    bus.cfg_n     = 32'd16;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_n",    bus.div_n, 32'd16);
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    #1;
    m_div_n = 32'd2;
    m_en    = 1'b0;
    m_err   = 1'b0;
    chk_quiet("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    gap(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/divider_cfg.md
DIVIDER_CFG -- requirements
Module: divider_cfg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, width of divide factor buses.
REQ-002 SHALL have parameter SETTLE, default 4, number of cycles div_n is held stable before div_enable rises; legal range 1..255.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cfg_valid  input  1  upstream offers cfg_n.
REQ-006 SHALL have port cfg_ready  output  1  block can accept a configuration this cycle.
REQ-007 SHALL have port cfg_n  input  WIDTH  requested divide factor; 0 means stop.
REQ-008 SHALL have port div_out  input  1  divided clock fed back from the downstream even divider.
REQ-009 SHALL have port div_n  output  WIDTH  divide factor driven to the even divider.
REQ-010 SHALL have port div_enable  output  1  enable driven to the even divider.
REQ-011 SHALL have port busy  output  1  reconfiguration in progress.
REQ-012 SHALL have port cfg_err  output  1  sticky flag: last offered factor was illegal.

Function
REQ-013 SHALL implement states IDLE, DRAIN, LOAD, SETTLE, RUN; all outputs registered except cfg_ready and busy, which are decoded from state.
REQ-014 SHALL drive cfg_ready=1 only in IDLE and RUN; transfer occurs on a rising edge with cfg_valid && cfg_ready.
REQ-015 SHALL classify a transferred cfg_n as: stop (==0), legal (even and >=2), or illegal (odd, including 1).
REQ-016 SHALL, on an illegal transfer, set cfg_err, hold state, div_n and div_enable unchanged, and keep cfg_ready=1.
REQ-017 SHALL clear cfg_err on the next legal or stop transfer; cfg_err is otherwise sticky.
REQ-018 SHALL, on a legal transfer, latch cfg_n into a pending register and go to DRAIN if div_enable=1, else to LOAD.
REQ-019 SHALL, on a stop transfer, go to DRAIN if div_enable=1, else stay in IDLE; div_n is never changed by a stop.
REQ-020 SHALL, in DRAIN, hold div_enable=1 until div_out is sampled 0, then clear div_enable on that edge and go to LOAD (legal) or IDLE (stop).
REQ-021 SHALL, in LOAD, copy pending to div_n on the next edge, load the settle counter with SETTLE-1, and go to SETTLE.
REQ-022 SHALL, in SETTLE, decrement the counter each edge; on the edge where it is 0, set div_enable=1 and go to RUN.
REQ-023 SHALL stay in RUN with div_enable=1 and div_n stable until a transfer occurs.
REQ-024 SHALL, from IDLE, raise div_enable exactly SETTLE+1 edges after the accepting edge (SETTLE=4: 5 edges).
REQ-025 SHALL drive busy=1 in DRAIN, LOAD and SETTLE, and 0 in IDLE and RUN.
REQ-026 SHALL run the full DRAIN/LOAD/SETTLE sequence even when the new legal cfg_n equals the current div_n.
REQ-027 SHALL ignore cfg_valid while cfg_ready=0; cfg_n is not sampled then.
REQ-028 SHALL never change div_n while div_enable=1.

Reset
REQ-029 SHALL, while reset=1, immediately force state=IDLE, div_n=2, div_enable=0, cfg_err=0, pending=2, settle counter=0; cfg_ready=1, busy=0.
REQ-030 SHALL, on reset asserted mid-sequence in any state, abandon the sequence without completing it; after release the block behaves as after power-up.

Verification
REQ-031 SHALL pass: reset, then cfg_n=8 offered one cycle in IDLE -> div_n=8 one edge after the accepting edge; div_enable rises 5 edges after accept; busy high for exactly the 5 intervening cycles.
REQ-032 SHALL pass: in RUN with div_n=8, offer cfg_n=4 while div_out=1 for 3 cycles -> div_enable stays 1 until div_out=0 is sampled, then falls; div_n becomes 4 only after div_enable=0; div_enable rises again SETTLE+1 edges later.
REQ-033 SHALL pass: offer cfg_n=7, then cfg_n=1 -> cfg_err=1 after each, div_n and div_enable unchanged, state unchanged; then cfg_n=6 -> cfg_err=0 and normal load.
REQ-034 SHALL pass: in RUN, offer cfg_n=0 -> DRAIN, div_enable falls at first div_out=0, state IDLE, div_n keeps previous value; cfg_n=0 in IDLE -> no change.
REQ-035 SHALL pass: assert reset during SETTLE (counter=2) -> outputs at reset values on the same edge-free cycle; after release, no div_enable rise without a new transfer.
REQ-036 SHALL pass: cfg_valid held high with changing cfg_n during busy -> no value sampled until cfg_ready=1; first value then present is the one accepted.
